// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode type, default geometry/thresholds and count-width helper for fifo_sync.
package fifo_pkg;

    typedef enum logic {FIFO_MODE_STD, FIFO_MODE_FWFT} fifo_mode_e;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_AF_LEVEL   = 14;
    localparam int FIFO_AE_LEVEL   = 2;

    // Occupancy must represent 0..depth inclusive, hence depth+1 codes.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// fifo_sync_if: producer/consumer handshake, status and error-flag bundle of fifo_sync.
interface fifo_sync_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;

    modport master (
        output wr, wr_data, rd, err_clr,
        input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, wr_data, rd, err_clr,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointers, occupancy, registered status flags and (with FIFO_ERR_FLAGS_EN) sticky error flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = FIFO_AF_LEVEL,
    parameter int AE_LEVEL   = FIFO_AE_LEVEL,
    localparam int DEPTH     = 2 ** ADDR_WIDTH,
    localparam int CW        = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                  err_clr,
`endif
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  wr_acc,
    output logic                  rd_acc,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [CW-1:0] DEP = CW'(DEPTH);
    localparam logic [CW-1:0] AF  = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE  = CW'(AE_LEVEL);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_level
        $error("fifo_ctrl: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
    end

    logic [CW-1:0] count_nxt;

    // A write into a full FIFO is accepted only when a read frees a slot that same cycle.
    always_comb begin
        rd_acc    = rd & ~empty;
        wr_acc    = wr & (~full | rd_acc);
        count_nxt = (wr_acc & ~rd_acc) ? count + CW'(1) :
                    (rd_acc & ~wr_acc) ? count - CW'(1) : count;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            count        <= count_nxt;
            full         <= count_nxt == DEP;
            empty        <= count_nxt == '0;
            almost_full  <= count_nxt >= AF;
            almost_empty <= count_nxt <= AE;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr & full & ~rd_acc) overflow <= 1'b1;
            if (rd & empty) underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: parametrised single-clock FIFO, storage and read path; standard or FWFT read via FWFT.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = FIFO_AF_LEVEL,
    parameter int AE_LEVEL   = FIFO_AE_LEVEL,
    parameter int FWFT       = 0
) (
    input logic       clk,
    input logic       reset_n,
    fifo_sync_if.slave bus
);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STD;

    logic [DATA_WIDTH-1:0] mem [2 ** ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  wr_acc, rd_acc;

    fifo_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
    ) u_ctrl (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (bus.wr),
        .rd           (bus.rd),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr      (bus.err_clr),
`endif
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .wr_acc       (wr_acc),
        .rd_acc       (rd_acc),
        .full         (bus.full),
        .empty        (bus.empty),
        .almost_full  (bus.almost_full),
        .almost_empty (bus.almost_empty),
        .count        (bus.count),
        .overflow     (bus.overflow),
        .underflow    (bus.underflow)
    );

`ifndef FIFO_ERR_FLAGS_EN
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
`endif

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.wr_data;
    end

    if (MODE == FIFO_MODE_FWFT) begin : g_fwft
        // Head is presented combinationally; popping only moves the read pointer.
        logic unused_rd_acc;
        assign unused_rd_acc = rd_acc;
        assign bus.rd_data   = bus.empty ? '0 : mem[rd_ptr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) rd_data_q <= '0;
            else if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
        assign bus.rd_data = rd_data_q;
    end
endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
Parametrised single-clock FIFO that generalises the fixed FIFO project. Adds:
- configurable data width and depth
- occupancy count
- programmable almost-full/almost-empty thresholds
- selectable read mode: registered (standard) or first-word-fall-through (FWFT)

It sits between producer and consumer blocks in the same clock domain, e.g. UART/IO staging.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
wr  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd  in  1  read request (FWFT: pop/acknowledge head)
rd_data  out  DATA_WIDTH  read data
full  out  1  no free entry
empty  out  1  no readable entry
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full (FIFO_ERR_FLAGS_EN only)
underflow  out  1  sticky: read attempted while empty (FIFO_ERR_FLAGS_EN only)
err_clr  in  1  clears overflow/underflow (FIFO_ERR_FLAGS_EN only)

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, rd_data = 0
  - storage array not reset
- Accept rules:
  - wr_acc = wr & (~full | rd_acc)
  - rd_acc = rd & ~empty
  - Write while full with no read is dropped; storage is unchanged.
  - Read while empty is ignored; rd_data holds its value.
- Pointers: ADDR_WIDTH bits; natural binary wrap-around DEPTH-1 -> 0.
- Count:
  - +1 on write only, -1 on read only, unchanged on both or neither.
  - Flags are registered, derived from next count; valid the same edge count updates.
- Simultaneous wr & rd:
  - When empty: write accepted, read rejected; count -> 1.
  - When full: both accepted; count stays DEPTH, full stays 1.
  - Otherwise: both accepted, count unchanged.
- Standard mode (FWFT=0):
  - rd_data loads mem[rd_ptr] on the edge of rd_acc; latency 1 cycle.
  - rd_data holds between reads.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally while ~empty; 0 when empty.
  - First write into an empty FIFO makes data visible and empty=0 one cycle after the write edge.
  - rd pops the head.
- Reset asserted mid-operation: all state returns to reset values immediately; contents are discarded logically.
- Out-of-range AF_LEVEL/AE_LEVEL: elaboration error via generate-time check.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on (wr & full & ~rd_acc); underflow sets on (rd & empty).
  - Both are sticky until err_clr is high for one cycle; err_clr has priority over a same-cycle set.
  - Reset value 0.
- Undefined:
  - overflow and underflow tied to 0.
  - err_clr ignored.
  - No flag registers are built.

Decomposition:
- Package fifo_pkg holds:
  - read-mode enum (FIFO_MODE_STD, FIFO_MODE_FWFT)
  - default width/depth/threshold constants
  - function clog2-based count-width helper
- One sub-module, fifo_ctrl, contains pointer, count, flag and error-flag logic. Parameters: ADDR_WIDTH, AF_LEVEL, AE_LEVEL. Outputs: wr_ptr, rd_ptr, wr_acc, rd_acc, flags.
- The top module fifo_sync holds the storage array, read-data path and mode generate.

Test Plan:
1. Reset, then 16 writes of 0x00..0x0F (defaults) -> count 16, full=1, almost_full=1 from the 14th write onward; 17th write 0xAA dropped, overflow=1 when enabled.
2. Drain 16 reads in standard mode -> rd_data 0x00..0x0F, each one cycle after its read; empty=1 after the last; an extra read leaves rd_data=0x0F and sets underflow=1.
3. Fill to 16, then wr+rd together with 0x55 -> count stays 16, full stays 1; 0x55 read out last after 15 further reads.
4. Write/read 40 words in alternation -> pointers wrap twice, data order preserved, count toggles 0/1.
5. FWFT=1, single write 0x3C -> next cycle empty=0 and rd_data=0x3C with no read; rd -> empty=1 on the following edge.
6. Assert reset_n low mid-burst at count 7 -> count=0, empty=1 and flags at reset values asynchronously; err_clr pulse clears sticky flags.
